// File: rtl/seq_gen_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : seq_gen_pkg                                                  |
// | Description : Shared types, defaults and helpers for the sequence emitter  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package seq_gen_pkg;

  localparam int         DATA_W_DEF   = 4;
  localparam logic [3:0] IDLE_SYM_DEF = 4'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // A pattern length is usable only when it names 1..depth memory entries.
  function automatic logic len_ok(input int unsigned len, input int unsigned depth);
    return (len != 0) && (len <= depth);
  endfunction

endpackage : seq_gen_pkg
`default_nettype wire

// File: rtl/seq_gen_mem.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : seq_gen_mem                                                  |
// | Description : Pattern register file, async clear, sync write, comb read    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module seq_gen_mem #(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 8,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              i_wr_en,
  input  logic [AW-1:0]     i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic [AW-1:0]     i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Storage: every entry clears on reset, single write port otherwise.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule : seq_gen_mem
`default_nettype wire

// File: rtl/seq_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : seq_gen                                                      |
// | Description : Programmable symbol-sequence emitter (pattern replay with    |
// |               repeat count and idle gaps between repetitions)              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module seq_gen
  import seq_gen_pkg::*;
#(
  parameter int                 DATA_W   = DATA_W_DEF,
  parameter int                 DEPTH    = 8,
  parameter int                 CNT_W    = 8,
  parameter logic [DATA_W-1:0]  IDLE_SYM = DATA_W'(IDLE_SYM_DEF),
  localparam int                AW       = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wr_en_i,
  input  logic [AW-1:0]     wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [AW:0]       len_i,
  input  logic [CNT_W-1:0]  rep_i,
  input  logic [CNT_W-1:0]  gap_i,
  input  logic              start_i,
  output logic              busy_o,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  output logic              last_o,
  output logic              done_o,
  output logic [CNT_W-1:0]  rep_cnt_o
);

  state_t            r_state, w_state_nxt;
  logic [AW-1:0]     r_idx, w_idx_nxt, w_idx_inc;
  logic [AW:0]       r_len;
  logic [CNT_W-1:0]  r_rep, r_gap;
  logic [CNT_W-1:0]  r_gap_cnt, w_gap_cnt_nxt;
  logic [CNT_W-1:0]  r_rep_cnt, w_rep_cnt_nxt, w_cnt_inc;
  logic [DATA_W-1:0] r_data, w_data_nxt;
  logic              r_valid, w_valid_nxt;
  logic              r_last, w_last_nxt;
  logic              r_done, w_done_nxt;
  logic [AW-1:0]     w_rd_addr;
  logic [DATA_W-1:0] w_rd_data;
  logic              w_start, w_start_ok, w_wr_en, w_len_one;

  // Requests are only honoured in IDLE; a start in the same cycle drops the write.
  assign w_start    = start_i && (r_state == ST_IDLE);
  assign w_wr_en    = wr_en_i && (r_state == ST_IDLE) && !start_i;
  assign w_start_ok = len_ok(32'(len_i), 32'(DEPTH)) && (rep_i != '0);
  assign w_idx_inc  = r_idx + AW'(1);
  assign w_cnt_inc  = r_rep_cnt + CNT_W'(1);
  assign w_len_one  = (r_len == (AW+1)'(1));

  // The only non-zero read address is the successor of the symbol on display.
  always_comb begin
    w_rd_addr = '0;
    if (r_state == ST_EMIT && !r_last) begin
      w_rd_addr = w_idx_inc;
    end
  end

  seq_gen_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_mem (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (wr_addr_i),
    .i_wr_data (wr_data_i),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_rd_data)
  );

  // Next state plus next registered outputs; outputs describe the cycle after the edge.
  always_comb begin
    w_state_nxt   = r_state;
    w_idx_nxt     = r_idx;
    w_gap_cnt_nxt = r_gap_cnt;
    w_rep_cnt_nxt = r_rep_cnt;
    w_data_nxt    = IDLE_SYM;
    w_valid_nxt   = 1'b0;
    w_last_nxt    = 1'b0;
    w_done_nxt    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start_i) begin
          w_rep_cnt_nxt = '0;
          if (w_start_ok) begin
            w_state_nxt = ST_EMIT;
            w_idx_nxt   = '0;
            w_data_nxt  = w_rd_data;
            w_valid_nxt = 1'b1;
            w_last_nxt  = (len_i == (AW+1)'(1));
          end else begin
            w_state_nxt = ST_DONE;
            w_done_nxt  = 1'b1;
          end
        end
      end
      ST_EMIT: begin
        if (r_last) begin
          w_rep_cnt_nxt = w_cnt_inc;
          if (w_cnt_inc == r_rep) begin
            w_state_nxt = ST_DONE;
            w_done_nxt  = 1'b1;
          end else if (r_gap != '0) begin
            w_state_nxt   = ST_GAP;
            w_gap_cnt_nxt = r_gap;
          end else begin
            w_idx_nxt   = '0;
            w_data_nxt  = w_rd_data;
            w_valid_nxt = 1'b1;
            w_last_nxt  = w_len_one;
          end
        end else begin
          w_idx_nxt   = w_idx_inc;
          w_data_nxt  = w_rd_data;
          w_valid_nxt = 1'b1;
          w_last_nxt  = ({1'b0, w_idx_inc} == (r_len - (AW+1)'(1)));
        end
      end
      ST_GAP: begin
        if (r_gap_cnt == CNT_W'(1)) begin
          w_state_nxt = ST_EMIT;
          w_idx_nxt   = '0;
          w_data_nxt  = w_rd_data;
          w_valid_nxt = 1'b1;
          w_last_nxt  = w_len_one;
        end else begin
          w_gap_cnt_nxt = r_gap_cnt - CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, counters and output registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= ST_IDLE;
      r_idx     <= '0;
      r_gap_cnt <= '0;
      r_rep_cnt <= '0;
      r_data    <= IDLE_SYM;
      r_valid   <= 1'b0;
      r_last    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_idx     <= w_idx_nxt;
      r_gap_cnt <= w_gap_cnt_nxt;
      r_rep_cnt <= w_rep_cnt_nxt;
      r_data    <= w_data_nxt;
      r_valid   <= w_valid_nxt;
      r_last    <= w_last_nxt;
      r_done    <= w_done_nxt;
    end
  end

  // Run parameters are captured on an accepted start and frozen for the run.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_len <= '0;
      r_rep <= '0;
      r_gap <= '0;
    end else if (w_start) begin
      r_len <= len_i;
      r_rep <= rep_i;
      r_gap <= gap_i;
    end
  end

  assign busy_o    = (r_state != ST_IDLE);
  assign data_o    = r_data;
  assign valid_o   = r_valid;
  assign last_o    = r_last;
  assign done_o    = r_done;
  assign rep_cnt_o = r_rep_cnt;

endmodule : seq_gen
`default_nettype wire

// File: tb/tb_seq_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_seq_gen                                                   |
// | Description : Self-checking bench for seq_gen                              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_seq_gen;

  localparam int DEPTH = 8;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       wr_en_i;
  logic [2:0] wr_addr_i;
  logic [3:0] wr_data_i;
  logic [3:0] len_i;
  logic [7:0] rep_i;
  logic [7:0] gap_i;
  logic       start_i;
  logic       busy_o;
  logic [3:0] data_o;
  logic       valid_o;
  logic       last_o;
  logic       done_o;
  logic [7:0] rep_cnt_o;

  seq_gen dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .wr_en_i   (wr_en_i),
    .wr_addr_i (wr_addr_i),
    .wr_data_i (wr_data_i),
    .len_i     (len_i),
    .rep_i     (rep_i),
    .gap_i     (gap_i),
    .start_i   (start_i),
    .busy_o    (busy_o),
    .data_o    (data_o),
    .valid_o   (valid_o),
    .last_o    (last_o),
    .done_o    (done_o),
    .rep_cnt_o (rep_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic       busy;
    logic       valid;
    logic       last;
    logic       done;
    logic [3:0] data;
    logic [7:0] cnt;
  } obs_t;

  typedef struct {
    int len;
    int rep;
    int gap;
    int done_at;
    int cnt;
  } vec_t;

  localparam obs_t RST_OBS = '{busy: 1'b0, valid: 1'b0, last: 1'b0, done: 1'b0,
                               data: 4'd7, cnt: 8'd0};

  int         errors = 0;
  int         checks = 0;
  logic [3:0] mdl_mem [DEPTH];

  // Detector stand-in for loopback: counts 1,2,3,4 in the valid-symbol stream.
  logic       det_clr = 1'b1;
  logic [15:0] det_win;
  int         det_found;

  always @(negedge clk_i) begin
    if (det_clr) begin
      det_win   <= '0;
      det_found <= 0;
    end else if (valid_o) begin
      det_win <= {det_win[11:0], data_o};
      if ({det_win[11:0], data_o} == 16'h1234) det_found <= det_found + 1;
    end
  end

  function automatic obs_t observe();
    return '{busy: busy_o, valid: valid_o, last: last_o, done: done_o,
             data: data_o, cnt: rep_cnt_o};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wr(input int addr, input logic [3:0] data);
    @(negedge clk_i);
    wr_en_i   = 1'b1;
    wr_addr_i = 3'(addr);
    wr_data_i = data;
    mdl_mem[addr] = data;
    @(negedge clk_i);
    wr_en_i = 1'b0;
  endtask

  task automatic load_1234();
    for (int i = 0; i < 4; i++) wr(i, 4'(i + 1));
  endtask

  // Expected per-cycle observation list, built straight from the replay rules.
  task automatic build_model(input int len, input int rep, input int gap, output obs_t q[$]);
    int cnt = 0;
    q = {};
    if (len < 1 || len > DEPTH || rep == 0) begin
      q.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 4'd7, 8'd0});
    end else begin
      for (int r = 0; r < rep; r++) begin
        for (int i = 0; i < len; i++) begin
          q.push_back('{1'b1, 1'b1, (i == len - 1), 1'b0, mdl_mem[i], 8'(cnt)});
        end
        cnt++;
        if (r < rep - 1) begin
          for (int g = 0; g < gap; g++) q.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 4'd7, 8'(cnt)});
        end
      end
      q.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 4'd7, 8'(cnt)});
    end
    q.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 4'd7, 8'(cnt)});
  endtask

  // One run: start, compare every cycle until back in IDLE. Optional busy-time
  // injection (inj), start/write collision, or reset abort at sample index.
  task automatic run(input int len, input int rep, input int gap, input int inj,
                     input bit collide, input int abort, output int done_at);
    obs_t q[$];
    build_model(len, rep, gap, q);
    done_at = -1;
    @(negedge clk_i);
    len_i   = 4'(len);
    rep_i   = 8'(rep);
    gap_i   = 8'(gap);
    start_i = 1'b1;
    if (collide) begin
      wr_en_i   = 1'b1;
      wr_addr_i = 3'd0;
      wr_data_i = 4'hF;
    end
    for (int k = 0; k < q.size(); k++) begin
      @(negedge clk_i);
      chk($sformatf("run_L%0d_R%0d_G%0d_cyc%0d", len, rep, gap, k + 1), 32'(observe()), 32'(q[k]));
      if (done_o && done_at < 0) done_at = k + 1;
      start_i = 1'b0;
      wr_en_i = 1'b0;
      if (k == inj) begin
        start_i   = 1'b1;
        len_i     = 4'd1;
        rep_i     = 8'd9;
        gap_i     = 8'd0;
        wr_en_i   = 1'b1;
        wr_addr_i = 3'd0;
        wr_data_i = 4'hA;
      end
      if (k == abort) begin
        #2 rst_i = 1'b1;
        #1 chk("abort_reset_immediate", 32'(observe()), 32'(RST_OBS));
        @(negedge clk_i);
        chk("abort_reset_held", 32'(observe()), 32'(RST_OBS));
        rst_i = 1'b0;
        for (int i = 0; i < DEPTH; i++) mdl_mem[i] = '0;
        return;
      end
    end
  endtask

  vec_t vecs[10];
  int   done_at;

  initial begin
    rst_i = 1'b1; wr_en_i = 1'b0; wr_addr_i = '0; wr_data_i = '0;
    len_i = '0; rep_i = '0; gap_i = '0; start_i = 1'b0;
    for (int i = 0; i < DEPTH; i++) mdl_mem[i] = '0;

    vecs[0] = '{4, 1, 0,  5, 1};
    vecs[1] = '{4, 3, 2, 17, 3};
    vecs[2] = '{0, 1, 0,  1, 0};
    vecs[3] = '{9, 1, 0,  1, 0};
    vecs[4] = '{4, 0, 0,  1, 0};
    vecs[5] = '{1, 1, 0,  2, 1};
    vecs[6] = '{8, 2, 0, 17, 2};
    vecs[7] = '{1, 4, 3, 14, 4};
    vecs[8] = '{8, 1, 5,  9, 1};
    vecs[9] = '{3, 2, 1,  8, 2};

    repeat (2) @(negedge clk_i);
    chk("reset_state", 32'(observe()), 32'(RST_OBS));
    rst_i = 1'b0;

    // Table-driven runs over the basic pattern plus upper entries.
    load_1234();
    wr(4, 4'h9); wr(5, 4'hA); wr(6, 4'hB); wr(7, 4'hC);
    foreach (vecs[v]) begin
      run(vecs[v].len, vecs[v].rep, vecs[v].gap, -1, 1'b0, -1, done_at);
      chk($sformatf("done_latency_v%0d", v), 32'(done_at), 32'(vecs[v].done_at));
      chk($sformatf("final_rep_cnt_v%0d", v), 32'(rep_cnt_o), 32'(vecs[v].cnt));
    end

    // Start and write while busy are both ignored; mem[0] still 1 afterwards.
    run(4, 2, 1, 3, 1'b0, -1, done_at);
    run(1, 1, 0, -1, 1'b0, -1, done_at);

    // Start/write collision in IDLE: run uses old contents, write is lost.
    run(4, 1, 0, -1, 1'b1, -1, done_at);
    run(1, 1, 0, -1, 1'b0, -1, done_at);

    // Randomized runs against the reference model.
    for (int it = 0; it < 15; it++) begin
      for (int w = 0; w < 3; w++) wr(int'($urandom_range(0, DEPTH - 1)), 4'($urandom));
      run(int'($urandom_range(0, 9)), int'($urandom_range(0, 4)),
          int'($urandom_range(0, 3)), -1, 1'b0, -1, done_at);
    end

    // Reset during the second repetition: no done, memory cleared.
    load_1234();
    run(4, 3, 1, -1, 1'b0, 6, done_at);
    repeat (3) begin
      @(negedge clk_i);
      chk("post_abort_no_done", 32'({busy_o, done_o}), 32'(2'b00));
    end
    run(8, 1, 0, -1, 1'b0, -1, done_at);

    // Loopback: detector target reloaded, one hit per repetition.
    load_1234();
    det_clr = 1'b0;
    run(4, 3, 1, -1, 1'b0, -1, done_at);
    @(negedge clk_i);
    chk("loopback_found_count", 32'(det_found), 32'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_seq_gen
`default_nettype wire
